// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - decode/writeback handshake bundle for the register scoreboard
//
// Purpose: carries the decode-stage issue request, the long-latency writeback
// and the flush, plus the combinational stall answer from the scoreboard.
// Signals:
//   issue_valid        decode requests issue this cycle
//   issue_regwrite_en  issuing instruction writes a register
//   issue_long         issuing instruction is long-latency
//   issue_rd           destination register
//   addr1, addr2       source registers
//   uses_op1, uses_op2 source is actually read
//   wb_valid, wb_addr  long-latency writeback this cycle
//   flush              decode-stage instruction squashed this cycle
//   stall              hold decode (driven by the scoreboard)
// Modports: master = decode/pipeline side, slave = scoreboard.

interface reg_scoreboard_if;
  logic       issue_valid;
  logic       issue_regwrite_en;
  logic       issue_long;
  logic [4:0] issue_rd;
  logic [4:0] addr1;
  logic [4:0] addr2;
  logic       uses_op1;
  logic       uses_op2;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic       flush;
  logic       stall;

  modport master (
    output issue_valid, issue_regwrite_en, issue_long, issue_rd,
    output addr1, addr2, uses_op1, uses_op2,
    output wb_valid, wb_addr, flush,
    input  stall
  );

  modport slave (
    input  issue_valid, issue_regwrite_en, issue_long, issue_rd,
    input  addr1, addr2, uses_op1, uses_op2,
    input  wb_valid, wb_addr, flush,
    output stall
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-long-write scoreboard with RAW/WAW stall and stall watchdog
//
// Purpose: tracks registers with an outstanding long-latency write, stalls
// decode on RAW/WAW hazards against them, and counts stall cycles.
// Ports:
//   clk           single clock, rising edge
//   reset         asynchronous active-low reset
//   sb            reg_scoreboard_if.slave (issue/writeback/flush in, stall out)
//   busy_vector   per-register pending-long-write bits (bit 0 always 0)
//   outstanding   number of set bits in busy_vector
//   stall_cycles  saturating count of stalled cycles
//   timeout       sticky: stall held for more than 255 consecutive cycles

module reg_scoreboard (
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb,
  output logic [31:0]      busy_vector,
  output logic [5:0]       outstanding,
  output logic [15:0]      stall_cycles,
  output logic             timeout
);

  logic [31:0] wb_mask;
  logic [31:0] set_mask;
  logic [31:0] eff_busy;
  logic        raw1;
  logic        raw2;
  logic        waw;
  logic        stall;
  logic        accept;
  logic        eff_clear;
  logic [7:0]  stall_run;

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (sb.wb_valid) wb_mask[sb.wb_addr] = 1'b1;

    // A writeback landing this cycle already resolves its hazard.
    eff_busy = busy_vector & ~wb_mask;

    raw1  = sb.uses_op1 & eff_busy[sb.addr1];
    raw2  = sb.uses_op2 & eff_busy[sb.addr2];
    waw   = sb.issue_regwrite_en & eff_busy[sb.issue_rd];
    stall = sb.issue_valid & ~sb.flush & (raw1 | raw2 | waw);

    accept = sb.issue_valid & ~stall & ~sb.flush & sb.issue_regwrite_en &
             sb.issue_long & (sb.issue_rd != 5'd0);
    if (accept) set_mask[sb.issue_rd] = 1'b1;

    // Writebacks to idle registers are ignored so the count cannot drift.
    eff_clear = |(busy_vector & wb_mask);
  end

  assign sb.stall = stall;

  // Clear before set so a same-cycle issue to the written-back register keeps its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vector <= '0;
      outstanding <= '0;
    end else begin
      busy_vector <= (busy_vector & ~wb_mask) | set_mask;
      if (accept && !eff_clear) begin
        outstanding <= outstanding + 6'd1;
      end else if (eff_clear && !accept) begin
        outstanding <= outstanding - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      stall_run    <= '0;
      timeout      <= 1'b0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      // stall_run holds at 255; one more stalled cycle trips the watchdog.
      if (!stall) begin
        stall_run <= '0;
      end else if (stall_run != 8'hFF) begin
        stall_run <= stall_run + 8'd1;
      end else begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard with a behavioural model
//
// Purpose: drives directed hazard scenarios and random traffic into
// reg_scoreboard and compares every output against a set-based model.
// Ports: none (top-level bench).

module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] busy_vector;
  logic [5:0]  outstanding;
  logic [15:0] stall_cycles;
  logic        timeout;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .sb           (sb_if.slave),
    .busy_vector  (busy_vector),
    .outstanding  (outstanding),
    .stall_cycles (stall_cycles),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;

  // Model state: set of pending registers, stall tally, current stall run length.
  logic [31:0] m_busy = '0;
  int          m_stall_cycles = 0;
  int          m_run = 0;
  bit          m_timeout = 1'b0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_stall();
    logic [31:0] pend;
    pend = m_busy;
    if (sb_if.wb_valid) pend[sb_if.wb_addr] = 1'b0;
    return sb_if.issue_valid && !sb_if.flush &&
           ((sb_if.uses_op1 && pend[sb_if.addr1]) ||
            (sb_if.uses_op2 && pend[sb_if.addr2]) ||
            (sb_if.issue_regwrite_en && pend[sb_if.issue_rd]));
  endfunction

  task automatic drive(input bit iv, input bit we, input bit lg, input logic [4:0] rd,
                       input logic [4:0] a1, input bit u1, input logic [4:0] a2, input bit u2,
                       input bit wv, input logic [4:0] wa, input bit fl);
    sb_if.issue_valid       = iv;
    sb_if.issue_regwrite_en = we;
    sb_if.issue_long        = lg;
    sb_if.issue_rd          = rd;
    sb_if.addr1             = a1;
    sb_if.uses_op1          = u1;
    sb_if.addr2             = a2;
    sb_if.uses_op2          = u2;
    sb_if.wb_valid          = wv;
    sb_if.wb_addr           = wa;
    sb_if.flush             = fl;
  endtask

  task automatic check_regs();
    check("busy_vector", busy_vector, m_busy);
    check("outstanding", {26'd0, outstanding}, $countones(m_busy));
    check("stall_cycles", {16'd0, stall_cycles}, m_stall_cycles);
    check("timeout", {31'd0, timeout}, {31'd0, m_timeout});
  endtask

  // Entered just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    bit s;
    bit acc;
    #1;
    s = model_stall();
    obs_stall = sb_if.stall;
    check("stall", {31'd0, sb_if.stall}, {31'd0, s});
    acc = sb_if.issue_valid && !s && !sb_if.flush && sb_if.issue_regwrite_en &&
          sb_if.issue_long && (sb_if.issue_rd != 5'd0);
    @(posedge clk);
    if (sb_if.wb_valid) m_busy[sb_if.wb_addr] = 1'b0;
    if (acc) m_busy[sb_if.issue_rd] = 1'b1;
    if (s) begin
      if (m_stall_cycles < 65535) m_stall_cycles++;
      m_run++;
      if (m_run > 255) m_timeout = 1'b1;
    end else begin
      m_run = 0;
    end
    #1;
    check_regs();
    @(negedge clk);
  endtask

  // Pulses reset between edges and checks the outputs before any clock edge.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    m_busy = '0;
    m_stall_cycles = 0;
    m_run = 0;
    m_timeout = 1'b0;
    check("rst_busy", busy_vector, 32'd0);
    check("rst_outstanding", {26'd0, outstanding}, 32'd0);
    check("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_stall", {31'd0, sb_if.stall}, {31'd0, model_stall()});
    #1;
    reset = 1'b1;
  endtask

  task automatic stall_on(input logic [4:0] r);
    drive(1, 0, 0, 0, r, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] sc_before;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    cycle();

    // Load-use on r5, resolved by a same-cycle writeback.
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
    stall_on(5); cycle();
    check("lu_stall", {31'd0, obs_stall}, 32'd1);
    check("lu_busy", busy_vector, 32'h20);
    check("lu_outstanding", {26'd0, outstanding}, 32'd1);
    drive(1, 0, 0, 0, 5, 1, 0, 0, 1, 5, 0); cycle();
    check("lu_bypass_stall", {31'd0, obs_stall}, 32'd0);
    check("lu_busy_clear", busy_vector, 32'h0);

    // WAW on r7 with writeback to r7 in the same cycle: set wins.
    drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 1, 7, 0, 0, 0, 0, 1, 7, 0); cycle();
    check("waw_stall", {31'd0, obs_stall}, 32'd0);
    check("waw_busy", busy_vector, 32'h80);
    check("waw_outstanding", {26'd0, outstanding}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle();
    // Writeback to an idle register is ignored.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); cycle();
    check("idle_wb_outstanding", {26'd0, outstanding}, 32'd0);

    // Register zero never becomes busy.
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    stall_on(0); cycle();
    check("r0_busy", busy_vector, 32'h0);
    check("r0_stall", {31'd0, obs_stall}, 32'd0);

    // Flush suppresses accept and stall.
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1); cycle();
    check("flush_busy", busy_vector, 32'h0);
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0); cycle();
    sc_before = stall_cycles;
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1); cycle();
    check("flush_stall", {31'd0, obs_stall}, 32'd0);
    check("flush_stall_cycles", {16'd0, stall_cycles}, {16'd0, sc_before});
    check("flush_keeps_busy", busy_vector, 32'h8);

    // Random traffic over a small register window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom_range(0, 1),
            $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      cycle();
    end

    // Watchdog boundary and stall counter saturation.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cycle();
    drive(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0); cycle();
    stall_on(9);
    for (int i = 0; i < 255; i++) cycle();
    check("to_before", {31'd0, timeout}, 32'd0);
    check("sc_255", {16'd0, stall_cycles}, 32'd255);
    cycle();
    check("to_after", {31'd0, timeout}, 32'd1);
    check("sc_256", {16'd0, stall_cycles}, 32'd256);
    for (int i = 0; i < 65284; i++) cycle();
    check("sc_saturated", {16'd0, stall_cycles}, 32'hFFFF);

    // Mid-operation reset with four pending writes and the watchdog tripped.
    drive(1, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 1, 11, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("pre_rst_outstanding", {26'd0, outstanding}, 32'd4);
    check("pre_rst_timeout", {31'd0, timeout}, 32'd1);
    drive(1, 1, 1, 4, 9, 1, 0, 0, 0, 0, 0);
    do_reset();
    cycle();
    check("post_rst_busy", busy_vector, 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL provide: CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: ISSUE_VALID  input  1  the instruction in decode requests issue this cycle.
REQ-004 SHALL provide: ISSUE_REGWRITE_EN  input  1  the issuing instruction writes a register.
REQ-005 SHALL provide: ISSUE_LONG  input  1  the issuing instruction is long-latency (load, mul/div); its result is not forwardable until writeback.
REQ-006 SHALL provide: ISSUE_RD  input  5  destination register address.
REQ-007 SHALL provide: ADDR1, ADDR2  input  5 each  source register addresses.
REQ-008 SHALL provide: USES_OP1, USES_OP2  input  1 each  the source is actually read.
REQ-009 SHALL provide: WB_VALID  input  1  long-latency result written back this cycle.
REQ-010 SHALL provide: WB_ADDR  input  5  register written back.
REQ-011 SHALL provide: FLUSH  input  1  the decode-stage instruction is squashed this cycle.
REQ-012 SHALL provide: STALL  output  1  hold decode; the instruction must not issue.
REQ-013 SHALL provide: BUSY_VECTOR  output  32  per-register pending-long-write bits.
REQ-014 SHALL provide: OUTSTANDING  output  6  number of set bits in BUSY_VECTOR.
REQ-015 SHALL provide: STALL_CYCLES  output  16  saturating count of cycles with STALL=1.
REQ-016 SHALL provide: TIMEOUT  output  1  sticky flag; STALL has been held too long.

Function
REQ-017 Effective busy SHALL be BUSY_VECTOR with bit WB_ADDR cleared when WB_VALID=1 (same-cycle writeback bypass).
REQ-018 STALL SHALL be combinational and equal ISSUE_VALID & ~FLUSH & (RAW1 | RAW2 | WAW).
- RAW1 = USES_OP1 & effbusy[ADDR1].
- RAW2 = USES_OP2 & effbusy[ADDR2].
- WAW = ISSUE_REGWRITE_EN & effbusy[ISSUE_RD].
REQ-019 Accept SHALL be ISSUE_VALID & ~STALL & ~FLUSH & ISSUE_REGWRITE_EN & ISSUE_LONG & (ISSUE_RD != 0).
- On accept, bit ISSUE_RD SHALL be set at the next edge.
REQ-020 With WB_VALID=1, bit WB_ADDR SHALL clear at the next edge.
- If WB_ADDR equals the ISSUE_RD of an accept in the same cycle, set SHALL win.
REQ-021 WB_VALID to a non-busy register SHALL be ignored; OUTSTANDING SHALL be unchanged.
REQ-022 Bit 0 SHALL never be set; register 0 SHALL never cause STALL.
REQ-023 OUTSTANDING SHALL update as follows:
- +1 on accept with no effective clear.
- -1 on effective clear of a set bit with no accept.
- Unchanged when both occur or neither occurs.
- Range 0..31, never wraps.
REQ-024 STALL_CYCLES SHALL increment on each cycle with STALL=1 and saturate at 16'hFFFF.
REQ-025 A consecutive-stall counter (8 bit) SHALL increment while STALL=1 and clear on any cycle with STALL=0.
- When it reaches 255 with STALL still 1, TIMEOUT SHALL set at the next edge.
- TIMEOUT SHALL remain set until reset.
REQ-026 FLUSH SHALL suppress both accept and STALL in that cycle; pending bits and writebacks SHALL be unaffected.
REQ-027 Latency: STALL same cycle; BUSY_VECTOR, OUTSTANDING and counters one cycle after the causing event.

Reset
REQ-028 RESET=0 SHALL immediately, without waiting for CLK, clear the following regardless of operation in progress:
- BUSY_VECTOR=0, OUTSTANDING=0, STALL_CYCLES=0, consecutive-stall counter=0, TIMEOUT=0.
REQ-029 During reset, STALL SHALL follow REQ-018 with all bits clear; in practice it is 0.
- The first edge after RESET returns to 1 SHALL process inputs normally.

Verification
REQ-030 Load-use: accept rd=5 (long); next cycle ADDR1=5, USES_OP1=1 -> STALL=1, BUSY_VECTOR=32'h20, OUTSTANDING=1.
- WB_VALID with WB_ADDR=5 -> STALL=0 in that same cycle; BUSY_VECTOR=0 next cycle.
REQ-031 WAW with simultaneous events: bit 7 busy; issue rd=7 with WB_ADDR=7 in the same cycle -> STALL=0, bit 7 remains 1, OUTSTANDING unchanged at 1.
REQ-032 Register zero: issue long with rd=0, then ADDR1=0 -> BUSY_VECTOR=0, STALL=0, OUTSTANDING=0.
REQ-033 FLUSH: issue long rd=3 with FLUSH=1 -> bit 3 not set, STALL=0.
- A stalled instruction flushed in the same cycle -> STALL=0; STALL_CYCLES does not increment.
REQ-034 Timeout and saturation: hold a RAW stall for 256 cycles -> TIMEOUT=1 and STALL_CYCLES=256.
- Preload STALL_CYCLES to 16'hFFFF via a long run -> it stays at 16'hFFFF.
REQ-035 Mid-operation reset: with 4 bits busy and TIMEOUT=1, pulse RESET low between edges -> all outputs clear immediately, before the next CLK.
